game_countdown_timer: RTL and testbench

Level countdown timer for the game. It consumes the single-cycle `one_sec` tick produced by the slow-clock tick generator and counts seconds down from a loaded value. The count is shown as two BCD digits for the seven-segment/on-screen score path. The block raises `time_up` when the count reaches zero, and supports start, pause/resume and bonus-time insertion from the game controller.

---
 rtl/game_countdown_timer.sv | 132 +++++++++++++
 tb/tb_game_countdown_timer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_countdown_timer.sv
// Level countdown timer: counts one_sec ticks down from START_SECS and shows the count as two BCD digits.
// Optional low-time warning output is enabled by defining COUNTDOWN_WARN_EN.
module game_countdown_timer #(
  parameter int unsigned START_SECS = 60,
  parameter int unsigned BONUS_SECS = 5
`ifdef COUNTDOWN_WARN_EN
  ,
  parameter int unsigned WARN_SECS  = 10
`endif
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       one_sec,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       add_bonus,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       time_up
`ifdef COUNTDOWN_WARN_EN
  ,
  output logic       warn
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] count_q, count_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       running_q, running_d;
  logic       time_up_q, time_up_d;
  logic [7:0] sum;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    time_up_d = 1'b0;
    sum       = {1'b0, count_q};

    if (load) begin
      state_d = IDLE;
      count_d = 7'(START_SECS);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (count_q == '0) begin
              state_d   = EXPIRED;
              time_up_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          // Bonus is added before the tick so a simultaneous pair saturates as min(99, n+B-1).
          if (add_bonus) sum = sum + 8'(BONUS_SECS);
          if (one_sec && sum != '0) sum = sum - 8'd1;
          if (sum > 8'd99) sum = 8'd99;
          count_d = sum[6:0];
          if (count_d == '0) begin
            state_d   = EXPIRED;
            time_up_d = 1'b1;
          end else if (pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (add_bonus) sum = sum + 8'(BONUS_SECS);
          if (sum > 8'd99) sum = 8'd99;
          count_d = sum[6:0];
          if (pause || start) state_d = RUN;
        end
        EXPIRED: ;
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
    tens_d    = 4'(count_d / 7'd10);
    ones_d    = 4'(count_d % 7'd10);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      count_q   <= 7'(START_SECS);
      tens_q    <= 4'(START_SECS / 10);
      ones_q    <= 4'(START_SECS % 10);
      running_q <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      running_q <= running_d;
      time_up_q <= time_up_d;
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign running = running_q;
  assign time_up = time_up_q;

`ifdef COUNTDOWN_WARN_EN
  logic warn_q, warn_d;

  always_comb begin
    warn_d = ((state_d == RUN) || (state_d == PAUSED)) &&
             (count_d != '0) && (count_d <= 7'(WARN_SECS));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) warn_q <= 1'b0;
    else         warn_q <= warn_d;
  end

  assign warn = warn_q;
`endif

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed self-checking bench for game_countdown_timer (main instance START_SECS=60, plus a START_SECS=0 instance).
module tb_game_countdown_timer;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       one_sec = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, add_bonus = 1'b0;
  logic [3:0] tens, ones, tens0, ones0;
  logic       running, time_up, running0, time_up0;
`ifdef COUNTDOWN_WARN_EN
  logic       warn, warn0;
`endif

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  game_countdown_timer #(.START_SECS(60), .BONUS_SECS(5)) dut (
    .clk(clk), .resetN(resetN), .one_sec(one_sec), .load(load), .start(start),
    .pause(pause), .add_bonus(add_bonus), .tens(tens), .ones(ones),
    .running(running), .time_up(time_up)
`ifdef COUNTDOWN_WARN_EN
    , .warn(warn)
`endif
  );

  game_countdown_timer #(.START_SECS(0), .BONUS_SECS(5)) dut0 (
    .clk(clk), .resetN(resetN), .one_sec(one_sec), .load(load), .start(start),
    .pause(pause), .add_bonus(add_bonus), .tens(tens0), .ones(ones0),
    .running(running0), .time_up(time_up0)
`ifdef COUNTDOWN_WARN_EN
    , .warn(warn0)
`endif
  );

  // Apply the currently driven inputs for one edge, then release all pulses; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    one_sec = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; add_bonus = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      one_sec = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #12;
    asserts++;
    if (tens !== 4'd6 || ones !== 4'd0 || running !== 1'b0 || time_up !== 1'b0) begin
      $display("FAIL reset: got %0d/%0d run=%b tu=%b, want 6/0 run=0 tu=0", tens, ones, running, time_up);
      fails++;
    end
    @(negedge clk);
    resetN = 1'b1;
    step();
  endtask

  task automatic test_countdown();
    int v;
    start = 1'b1;
    step();
    asserts++;
    if (running !== 1'b1 || tens !== 4'd6 || ones !== 4'd0) begin
      $display("FAIL start: got %0d/%0d run=%b, want 6/0 run=1", tens, ones, running);
      fails++;
    end
    for (int k = 1; k <= 60; k++) begin
      v = 60 - k;
      ticks(1);
      asserts++;
      if (tens !== 4'(v / 10) || ones !== 4'(v % 10) || time_up !== (v == 0) || running !== (v != 0)) begin
        $display("FAIL countdown: got %0d/%0d tu=%b run=%b, want %0d/%0d tu=%b run=%b",
                 tens, ones, time_up, running, v / 10, v % 10, v == 0, v != 0);
        fails++;
      end
    end
    step();
    asserts++;
    if (time_up !== 1'b0 || tens !== 4'd0 || ones !== 4'd0) begin
      $display("FAIL time_up_width: got tu=%b %0d/%0d, want tu=0 0/0", time_up, tens, ones);
      fails++;
    end
  endtask

  task automatic test_pause();
    load = 1'b1; step();
    start = 1'b1; step();
    ticks(37);
    asserts++;
    if (tens !== 4'd2 || ones !== 4'd3) begin
      $display("FAIL pause_setup: got %0d/%0d, want 2/3", tens, ones);
      fails++;
    end
    pause = 1'b1; step();
    asserts++;
    if (running !== 1'b0 || tens !== 4'd2 || ones !== 4'd3) begin
      $display("FAIL pause_enter: got %0d/%0d run=%b, want 2/3 run=0", tens, ones, running);
      fails++;
    end
    ticks(5);
    asserts++;
    if (running !== 1'b0 || tens !== 4'd2 || ones !== 4'd3) begin
      $display("FAIL pause_hold: got %0d/%0d run=%b, want 2/3 run=0", tens, ones, running);
      fails++;
    end
    pause = 1'b1; step();
    asserts++;
    if (running !== 1'b1 || tens !== 4'd2 || ones !== 4'd3) begin
      $display("FAIL pause_resume: got %0d/%0d run=%b, want 2/3 run=1", tens, ones, running);
      fails++;
    end
    ticks(1);
    asserts++;
    if (running !== 1'b1 || tens !== 4'd2 || ones !== 4'd2) begin
      $display("FAIL pause_tick: got %0d/%0d run=%b, want 2/2 run=1", tens, ones, running);
      fails++;
    end
  endtask

  task automatic test_bonus();
    load = 1'b1; step();
    start = 1'b1; step();
    ticks(3);
    for (int i = 0; i < 8; i++) begin
      add_bonus = 1'b1; step();
    end
    asserts++;
    if (tens !== 4'd9 || ones !== 4'd7) begin
      $display("FAIL bonus_97: got %0d/%0d, want 9/7", tens, ones);
      fails++;
    end
    add_bonus = 1'b1; step();
    asserts++;
    if (tens !== 4'd9 || ones !== 4'd9) begin
      $display("FAIL bonus_sat: got %0d/%0d, want 9/9", tens, ones);
      fails++;
    end
    ticks(98);
    asserts++;
    if (tens !== 4'd0 || ones !== 4'd1 || running !== 1'b1) begin
      $display("FAIL bonus_01: got %0d/%0d run=%b, want 0/1 run=1", tens, ones, running);
      fails++;
    end
    add_bonus = 1'b1; one_sec = 1'b1; step();
    asserts++;
    if (tens !== 4'd0 || ones !== 4'd5 || time_up !== 1'b0 || running !== 1'b1) begin
      $display("FAIL bonus_tick: got %0d/%0d tu=%b run=%b, want 0/5 tu=0 run=1", tens, ones, time_up, running);
      fails++;
    end
    pause = 1'b1; one_sec = 1'b1; step();
    asserts++;
    if (tens !== 4'd0 || ones !== 4'd4 || running !== 1'b0) begin
      $display("FAIL pause_tick_same: got %0d/%0d run=%b, want 0/4 run=0", tens, ones, running);
      fails++;
    end
  endtask

  task automatic test_expired();
    pause = 1'b1; step();
    ticks(3);
    asserts++;
    if (tens !== 4'd0 || ones !== 4'd1 || time_up !== 1'b0) begin
      $display("FAIL expire_pre: got %0d/%0d tu=%b, want 0/1 tu=0", tens, ones, time_up);
      fails++;
    end
    ticks(1);
    asserts++;
    if (tens !== 4'd0 || ones !== 4'd0 || time_up !== 1'b1 || running !== 1'b0) begin
      $display("FAIL expire: got %0d/%0d tu=%b run=%b, want 0/0 tu=1 run=0", tens, ones, time_up, running);
      fails++;
    end
    start = 1'b1; step();
    pause = 1'b1; step();
    add_bonus = 1'b1; one_sec = 1'b1; step();
    ticks(3);
    asserts++;
    if (tens !== 4'd0 || ones !== 4'd0 || time_up !== 1'b0 || running !== 1'b0) begin
      $display("FAIL expired_ignore: got %0d/%0d tu=%b run=%b, want 0/0 tu=0 run=0", tens, ones, time_up, running);
      fails++;
    end
    load = 1'b1; step();
    asserts++;
    if (tens !== 4'd6 || ones !== 4'd0 || running !== 1'b0) begin
      $display("FAIL load: got %0d/%0d run=%b, want 6/0 run=0", tens, ones, running);
      fails++;
    end
    ticks(2);
    asserts++;
    if (tens !== 4'd6 || ones !== 4'd0 || running !== 1'b0) begin
      $display("FAIL idle_ignore: got %0d/%0d run=%b, want 6/0 run=0", tens, ones, running);
      fails++;
    end
    load = 1'b1; start = 1'b1; step();
    asserts++;
    if (tens !== 4'd6 || ones !== 4'd0 || running !== 1'b0) begin
      $display("FAIL load_start: got %0d/%0d run=%b, want 6/0 run=0", tens, ones, running);
      fails++;
    end
    start = 1'b1; one_sec = 1'b1; step();
    ticks(1);
    asserts++;
    if (tens !== 4'd5 || ones !== 4'd9 || running !== 1'b1) begin
      $display("FAIL restart: got %0d/%0d run=%b, want 5/9 run=1", tens, ones, running);
      fails++;
    end
  endtask

  task automatic test_async_reset();
    ticks(4);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    asserts++;
    if (tens !== 4'd6 || ones !== 4'd0 || running !== 1'b0 || time_up !== 1'b0) begin
      $display("FAIL async_reset: got %0d/%0d run=%b tu=%b, want 6/0 run=0 tu=0", tens, ones, running, time_up);
      fails++;
    end
    @(negedge clk);
    resetN = 1'b1;
    step();
  endtask

  task automatic test_zero_start();
    asserts++;
    if (tens0 !== 4'd0 || ones0 !== 4'd0 || time_up0 !== 1'b0) begin
      $display("FAIL zero_reset: got %0d/%0d tu=%b, want 0/0 tu=0", tens0, ones0, time_up0);
      fails++;
    end
    start = 1'b1; step();
    asserts++;
    if (tens0 !== 4'd0 || ones0 !== 4'd0 || time_up0 !== 1'b1 || running0 !== 1'b0) begin
      $display("FAIL zero_start: got %0d/%0d tu=%b run=%b, want 0/0 tu=1 run=0", tens0, ones0, time_up0, running0);
      fails++;
    end
    start = 1'b1; step();
    asserts++;
    if (time_up0 !== 1'b0 || running0 !== 1'b0) begin
      $display("FAIL zero_once: got tu=%b run=%b, want tu=0 run=0", time_up0, running0);
      fails++;
    end
  endtask

`ifdef COUNTDOWN_WARN_EN
  task automatic test_warn();
    int v;
    load = 1'b1; step();
    asserts++;
    if (warn !== 1'b0) begin
      $display("FAIL warn_idle: got %b, want 0", warn);
      fails++;
    end
    start = 1'b1; step();
    ticks(48);
    asserts++;
    if (tens !== 4'd1 || ones !== 4'd2 || warn !== 1'b0) begin
      $display("FAIL warn_12: got %0d/%0d warn=%b, want 1/2 warn=0", tens, ones, warn);
      fails++;
    end
    for (int k = 1; k <= 12; k++) begin
      v = 12 - k;
      ticks(1);
      asserts++;
      if (warn !== (v >= 1 && v <= 10) || tens !== 4'(v / 10) || ones !== 4'(v % 10)) begin
        $display("FAIL warn_level: got %0d/%0d warn=%b, want %0d/%0d warn=%b",
                 tens, ones, warn, v / 10, v % 10, v >= 1 && v <= 10);
        fails++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_bonus();
    test_expired();
    test_async_reset();
    test_zero_start();
`ifdef COUNTDOWN_WARN_EN
    test_warn();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
